// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: sequences fetch/decode/exec/mem/writeback over a shared ALU
// and a single memory port, trapping on unsupported opcodes or memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic [31:0]      ir_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_load_o,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BR     = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic [6:0] opcode;
  logic       is_op, is_op_imm, is_load, is_store, is_branch, is_lui, legal;
  logic [1:0] ex_a, ex_b, ex_op;
  logic       tmo_hit;
  logic       unused_ir;
  state_e     after_retire;

  assign opcode    = ir_i[6:0];
  assign unused_ir = ^ir_i[31:7];

  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_lui    = (opcode == OPC_LUI);
  assign legal     = is_op | is_op_imm | is_load | is_store | is_branch | is_lui;

  // Final wait cycle of an access that still has not completed.
  assign tmo_hit      = !mem_ready_i && (wait_q == TMO_W'(TIMEOUT - 1));
  assign after_retire = run_i ? S_FETCH : S_IDLE;

  // ALU operand/op selection for the execute step; held through MEM/WB so ALU result stays stable.
  always_comb begin
    ex_a  = SRC_A_RS1;
    ex_b  = SRC_B_IMM;
    ex_op = ALU_ADD;
    if (is_op) begin
      ex_b  = SRC_B_RS2;
      ex_op = ALU_FUNCT;
    end else if (is_op_imm) begin
      ex_op = ALU_FUNCT;
    end else if (is_branch) begin
      ex_b  = SRC_B_RS2;
      ex_op = ALU_BR;
    end else if (is_lui) begin
      ex_a  = SRC_A_ZERO;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_d          = '0;
    instret_d       = instret_q;
    illegal_d       = illegal_q;
    bus_err_d       = bus_err_q;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    iord_o          = 1'b0;
    ir_load_o       = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    alu_src_a_o     = SRC_A_PC;
    alu_src_b_o     = SRC_B_RS2;
    alu_op_o        = ALU_ADD;
    reg_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        if (mem_ready_i) begin
          ir_load_o  = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (tmo_hit) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        alu_src_b_o = SRC_B_IMM;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_src_a_o = ex_a;
        alu_src_b_o = ex_b;
        alu_op_o    = ex_op;
        if (is_branch) begin
          pc_write_cond_o = 1'b1;
          instret_d       = instret_q + CNT_W'(1);
          state_d         = after_retire;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_o   = 1'b1;
        iord_o      = 1'b1;
        mem_we_o    = is_store;
        alu_src_a_o = ex_a;
        alu_src_b_o = ex_b;
        alu_op_o    = ex_op;
        if (mem_ready_i) begin
          if (is_store) begin
            instret_d = instret_q + CNT_W'(1);
            state_d   = after_retire;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = is_load;
        alu_src_a_o  = ex_a;
        alu_src_b_o  = ex_b;
        alu_op_o     = ex_op;
        instret_d    = instret_q + CNT_W'(1);
        state_d      = after_retire;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign instret_o = instret_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;

endmodule
